// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage controller: branch condition codes,
// flag bit positions and the memory-access FSM states.
package mem_stage_pkg;

  localparam logic [2:0] BR_NEQ  = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_GT   = 3'b010;
  localparam logic [2:0] BR_LT   = 3'b011;
  localparam logic [2:0] BR_GTE  = 3'b100;
  localparam logic [2:0] BR_LTE  = 3'b101;
  localparam logic [2:0] BR_OVFL = 3'b110;
  localparam logic [2:0] BR_UNC  = 3'b111;

  localparam int FLAG_OV = 2;
  localparam int FLAG_ZR = 1;
  localparam int FLAG_NE = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic branch_cond(input logic [2:0] op, input logic [2:0] flags);
    logic ov, zr, ne;
    ov = flags[FLAG_OV];
    zr = flags[FLAG_ZR];
    ne = flags[FLAG_NE];
    case (op)
      BR_NEQ:  return ~zr;
      BR_EQ:   return zr;
      BR_GT:   return ~(zr | ne);
      BR_LT:   return ne;
      BR_GTE:  return ~ne;
      BR_LTE:  return ne | zr;
      BR_OVFL: return ov;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_branch_resolve.sv
// Combinational branch/jump resolution for the instruction in MEM.
// Redirect target priority: jal, then jr, then conditional branch.
module branch_resolve
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic [2:0]        branch_op,
  input  logic [2:0]        flags,
  input  logic              b,
  input  logic              jal,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jal_result,
  input  logic [ADDR_W-1:0] jr_result,
  input  logic [ADDR_W-1:0] branch_result,
  output logic              branch_raw,
  output logic [ADDR_W-1:0] branch_addr
);

  logic w_cond;

  assign w_cond     = branch_cond(branch_op, flags);
  assign branch_raw = jal | jr | (b & w_cond);

  always_comb begin
    if (jal)     branch_addr = jal_result;
    else if (jr) branch_addr = jr_result;
    else         branch_addr = branch_result;
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: req/gnt/rvalid data-memory handshake with pipeline
// stall, access timeout, and writeback/flag/branch qualification.
module mem_stage_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic              reg_we,
  input  logic              addz,
  input  logic              b,
  input  logic              jal,
  input  logic              jr,
  input  logic [2:0]        flags,
  input  logic [2:0]        flag_en_in,
  input  logic [2:0]        branch_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] wrt_data,
  input  logic [ADDR_W-1:0] jal_result,
  input  logic [ADDR_W-1:0] jr_result,
  input  logic [ADDR_W-1:0] branch_result,
  output logic              stall,
  output logic [DATA_W-1:0] mem_data,
  output logic              reg_write_enable,
  output logic [2:0]        flag_en_out,
  output logic              branch,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              timeout_err,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [DATA_W-1:0] dm_rdata
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_discard;
  logic             r_tmo_done;
  logic             w_new_op, w_busy, w_in_req, w_in_wait;
  logic             w_tmo_hit, w_tmo_abort, w_load_cap, w_qual, w_br_raw;

  assign w_in_req  = (r_state == ST_REQ);
  assign w_in_wait = (r_state == ST_WAIT);
  assign w_busy    = w_in_req | w_in_wait;

  // The instruction aborted by a timeout is still held in EX/MEM for one cycle;
  // r_tmo_done lets it retire instead of being reissued.
  assign w_new_op = in_valid & (mem_re | mem_we) & ~flush & ~r_tmo_done;

  // A grant or read response in the final cycle wins over the timeout.
  assign w_tmo_hit   = (TIMEOUT_CYC != 0) && w_busy && (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign w_tmo_abort = w_tmo_hit & ((w_in_req & ~dm_gnt) | (w_in_wait & ~dm_rvalid));
  assign w_load_cap  = w_in_wait & dm_rvalid & ~r_discard & ~flush;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_new_op) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (dm_gnt)                     w_state_nxt = mem_we ? ST_DONE : ST_WAIT;
        else if (flush || w_tmo_abort)  w_state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (dm_rvalid)        w_state_nxt = (r_discard || flush) ? ST_IDLE : ST_DONE;
        else if (w_tmo_abort) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_discard   <= 1'b0;
      r_tmo_done  <= 1'b0;
      timeout_err <= 1'b0;
      mem_data    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmo_cnt  <= w_busy ? r_tmo_cnt + 1'b1 : '0;
      r_tmo_done <= w_tmo_abort;
      if (w_tmo_abort) timeout_err <= 1'b1;
      if (w_load_cap)  mem_data    <= dm_rdata;
      // Read data still owed by memory after a flush must be swallowed.
      if (w_state_nxt != ST_WAIT)
        r_discard <= 1'b0;
      else if (flush && ((w_in_req && dm_gnt) || w_in_wait))
        r_discard <= 1'b1;
    end
  end

  assign stall    = ((r_state == ST_IDLE) & w_new_op) | w_busy;
  assign dm_req   = w_in_req;
  assign dm_we    = mem_we;
  assign dm_addr  = mem_addr;
  assign dm_wdata = wrt_data;

  assign w_qual           = in_valid & ~flush & ~stall;
  assign reg_write_enable = w_qual & (reg_we | (addz & flags[FLAG_ZR]));
  assign flag_en_out      = (~addz | flags[FLAG_ZR]) ? flag_en_in : 3'b000;
  assign branch           = w_qual & w_br_raw;

  branch_resolve #(
    .ADDR_W (ADDR_W)
  ) u_branch_resolve (
    .branch_op     (branch_op),
    .flags         (flags),
    .b             (b),
    .jal           (jal),
    .jr            (jr),
    .jal_result    (jal_result),
    .jr_result     (jr_result),
    .branch_result (branch_result),
    .branch_raw    (w_br_raw),
    .branch_addr   (branch_addr)
  );

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl; memory completions are checked by a
// scoreboard monitor, combinational outputs by direct comparisons.
module tb_mem_stage_ctrl;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush, in_valid, mem_re, mem_we, reg_we, addz, b, jal, jr;
  logic [2:0]    flags, flag_en_in, branch_op;
  logic [AW-1:0] mem_addr, jal_result, jr_result, branch_result;
  logic [DW-1:0] wrt_data;
  logic          stall, reg_write_enable, branch, timeout_err;
  logic [DW-1:0] mem_data;
  logic [2:0]    flag_en_out;
  logic [AW-1:0] branch_addr, dm_addr;
  logic          dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_wdata, dm_rdata;

  typedef struct {
    logic [DW-1:0] data;
    logic          rwe;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_acc    = 0;

  mem_stage_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .mem_re(mem_re), .mem_we(mem_we), .reg_we(reg_we), .addz(addz),
    .b(b), .jal(jal), .jr(jr), .flags(flags), .flag_en_in(flag_en_in),
    .branch_op(branch_op), .mem_addr(mem_addr), .wrt_data(wrt_data),
    .jal_result(jal_result), .jr_result(jr_result), .branch_result(branch_result),
    .stall(stall), .mem_data(mem_data), .reg_write_enable(reg_write_enable),
    .flag_en_out(flag_en_out), .branch(branch), .branch_addr(branch_addr),
    .timeout_err(timeout_err), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
    .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    flush = 0; in_valid = 0; mem_re = 0; mem_we = 0; reg_we = 0; addz = 0;
    b = 0; jal = 0; jr = 0; flags = 0; flag_en_in = 0; branch_op = 0;
    mem_addr = 0; wrt_data = 0; jal_result = 0; jr_result = 0; branch_result = 0;
    dm_gnt = 0; dm_rvalid = 0; dm_rdata = 0;
  endtask

  function automatic logic ref_cond(input logic [2:0] op, input logic [2:0] f);
    logic ov, zr, ne;
    {ov, zr, ne} = f;
    case (op)
      3'd0: ref_cond = !zr;
      3'd1: ref_cond = zr;
      3'd2: ref_cond = !(zr || ne);
      3'd3: ref_cond = ne;
      3'd4: ref_cond = !ne;
      3'd5: ref_cond = ne || zr;
      3'd6: ref_cond = ov;
      default: ref_cond = 1'b1;
    endcase
  endfunction

  // Scoreboard monitor: a memory instruction retires when it is presented
  // without stall; its writeback data and enable are compared then.
  always @(negedge clk) begin
    if (!rst) begin
      if (dm_req && dm_gnt) n_acc++;
      if (in_valid && (mem_re || mem_we) && !flush && !stall) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: completion with mem_data %0h, none expected", mem_data);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_mem_data", 32'(mem_data), 32'(e.data));
          check("sb_rwe", 32'(reg_write_enable), 32'(e.rwe));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    rst = 1'b1;
    clr();
    #12;
    check("rst_stall", 32'(stall), 0);
    check("rst_dm_req", 32'(dm_req), 0);
    check("rst_mem_data", 32'(mem_data), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_rwe", 32'(reg_write_enable), 0);
    @(negedge clk) rst = 1'b0;
    to_next();

    // Load 0x0040: gnt in cycle 1, rvalid 0xBEEF in cycle 3, retire in cycle 4.
    in_valid = 1; mem_re = 1; reg_we = 1; mem_addr = 16'h0040;
    sb_q.push_back('{16'hBEEF, 1'b1});
    @(negedge clk) check("ld_c0_stall", 32'(stall), 1);
    to_next(); dm_gnt = 1;
    @(negedge clk) begin
      check("ld_c1_req", 32'(dm_req), 1);
      check("ld_c1_addr", 32'(dm_addr), 32'h0040);
      check("ld_c1_we", 32'(dm_we), 0);
      check("ld_c1_stall", 32'(stall), 1);
    end
    to_next(); dm_gnt = 0;
    @(negedge clk) check("ld_c2_stall", 32'(stall), 1);
    to_next(); dm_rvalid = 1; dm_rdata = 16'hBEEF;
    @(negedge clk) check("ld_c3_stall", 32'(stall), 1);
    to_next(); dm_rvalid = 0; dm_rdata = 0;
    @(negedge clk) check("ld_c4_stall", 32'(stall), 0);
    to_next(); clr();

    // Store 0x1234 -> 0x0010 with gnt held off for 3 request cycles.
    acc0 = n_acc;
    in_valid = 1; mem_we = 1; mem_addr = 16'h0010; wrt_data = 16'h1234;
    sb_q.push_back('{16'hBEEF, 1'b0});
    @(negedge clk) check("st_c0_stall", 32'(stall), 1);
    for (int i = 0; i < 4; i++) begin
      to_next();
      dm_gnt = (i == 3);
      @(negedge clk) begin
        check("st_req", 32'(dm_req), 1);
        check("st_addr", 32'(dm_addr), 32'h0010);
        check("st_wdata", 32'(dm_wdata), 32'h1234);
        check("st_we", 32'(dm_we), 1);
        check("st_stall_req", 32'(stall), 1);
      end
    end
    to_next(); dm_gnt = 0;
    @(negedge clk) begin
      check("st_stall_after_gnt", 32'(stall), 0);
      check("st_req_after_gnt", 32'(dm_req), 0);
    end
    to_next(); clr();
    check("st_one_accept", 32'(n_acc - acc0), 1);

    // Flush while waiting for read data: response 0xAAAA must be dropped.
    in_valid = 1; mem_re = 1; reg_we = 1; mem_addr = 16'h0020;
    to_next(); dm_gnt = 1;
    to_next(); dm_gnt = 0; flush = 1;
    @(negedge clk) check("fl_wait_stall", 32'(stall), 1);
    to_next(); flush = 0; in_valid = 0; mem_re = 0; reg_we = 0;
    @(negedge clk) check("fl_hold_stall", 32'(stall), 1);
    to_next(); dm_rvalid = 1; dm_rdata = 16'hAAAA;
    @(negedge clk) check("fl_rvalid_stall", 32'(stall), 1);
    to_next(); dm_rvalid = 0; dm_rdata = 0;
    @(negedge clk) begin
      check("fl_after_stall", 32'(stall), 0);
      check("fl_mem_data_kept", 32'(mem_data), 32'hBEEF);
      check("fl_rwe", 32'(reg_write_enable), 0);
    end
    to_next();

    // Next load after the flush issues normally: 0x5A5A at minimum latency.
    in_valid = 1; mem_re = 1; reg_we = 1; mem_addr = 16'h0030;
    sb_q.push_back('{16'h5A5A, 1'b1});
    to_next(); dm_gnt = 1;
    @(negedge clk) check("ld2_addr", 32'(dm_addr), 32'h0030);
    to_next(); dm_gnt = 0; dm_rvalid = 1; dm_rdata = 16'h5A5A;
    to_next(); dm_rvalid = 0; dm_rdata = 0;
    @(negedge clk) check("ld2_done_stall", 32'(stall), 0);
    to_next(); clr();

    // A jal held by a stalled load must not redirect until the load retires.
    in_valid = 1; mem_re = 1; jal = 1; jal_result = 16'h0ABC; mem_addr = 16'h0034;
    sb_q.push_back('{16'h1111, 1'b0});
    @(negedge clk) check("stalled_branch", 32'(branch), 0);
    to_next(); dm_gnt = 1;
    to_next(); dm_gnt = 0; dm_rvalid = 1; dm_rdata = 16'h1111;
    to_next(); dm_rvalid = 0; dm_rdata = 0;
    @(negedge clk) begin
      check("retire_branch", 32'(branch), 1);
      check("retire_branch_addr", 32'(branch_addr), 32'h0ABC);
    end
    to_next(); clr();

    // Timeout: no grant for 4 request cycles.
    in_valid = 1; mem_re = 1; mem_addr = 16'h0050;
    sb_q.push_back('{16'h1111, 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) check("tmo_stall", 32'(stall), 1);
      to_next();
    end
    @(negedge clk) begin
      check("tmo_err_set", 32'(timeout_err), 1);
      check("tmo_req_drop", 32'(dm_req), 0);
      check("tmo_stall_release", 32'(stall), 0);
    end
    to_next(); clr();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) begin
        check("tmo_err_sticky", 32'(timeout_err), 1);
        check("tmo_idle_req", 32'(dm_req), 0);
        check("tmo_idle_stall", 32'(stall), 0);
      end
      to_next();
    end

    // Branch condition sweep, combinational with no memory op in flight.
    in_valid = 1; b = 1; branch_result = 16'h3000;
    for (int op = 0; op < 8; op++) begin
      for (int f = 0; f < 8; f++) begin
        branch_op = 3'(op);
        flags = 3'(f);
        #1;
        check($sformatf("br_op%0d_f%0d", op, f), 32'(branch), 32'(ref_cond(3'(op), 3'(f))));
      end
    end
    b = 0; jal = 1; jr = 1; jal_result = 16'h1000; jr_result = 16'h2000; #1;
    check("jal_jr_branch", 32'(branch), 1);
    check("jal_jr_addr", 32'(branch_addr), 32'h1000);
    jal = 0; #1;
    check("jr_addr", 32'(branch_addr), 32'h2000);
    jr = 0; b = 1; branch_op = 3'd7; #1;
    check("b_addr", 32'(branch_addr), 32'h3000);
    b = 0; flags = 0;

    // Conditional writeback and flag enables.
    addz = 1; flag_en_in = 3'b111; flags = 3'b000; #1;
    check("addz_nz_rwe", 32'(reg_write_enable), 0);
    check("addz_nz_flag_en", 32'(flag_en_out), 0);
    flags = 3'b010; flag_en_in = 3'b101; #1;
    check("addz_z_rwe", 32'(reg_write_enable), 1);
    check("addz_z_flag_en", 32'(flag_en_out), 32'b101);
    addz = 0; flags = 3'b000; flag_en_in = 3'b011; flush = 1; #1;
    check("flag_en_ungated", 32'(flag_en_out), 32'b011);
    check("flush_rwe", 32'(reg_write_enable), 0);
    clr();
    to_next();

    // Reset asserted mid-request drops dm_req without waiting for a clock.
    in_valid = 1; mem_re = 1; mem_addr = 16'h0060;
    to_next();
    @(negedge clk) check("rst_mid_req_before", 32'(dm_req), 1);
    #1 rst = 1; in_valid = 0; mem_re = 0;
    #1 begin
      check("rst_mid_req_drop", 32'(dm_req), 0);
      check("rst_mid_stall", 32'(stall), 0);
      check("rst_mid_err_clr", 32'(timeout_err), 0);
      check("rst_mid_mem_data", 32'(mem_data), 0);
    end
    @(negedge clk) rst = 0;
    to_next();
    @(negedge clk) check("post_rst_req", 32'(dm_req), 0);

    check("sb_drained", 32'(sb_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
